coord_track_filter: RTL and testbench
=====================================

Name: coord_track_filter

Overview:
- Sits directly downstream of the red-group detector. Consumes its per-frame row/column centroid, frame-boundary strobe and presence flag.
- Produces a temporally smoothed, outlier-rejected target coordinate with a tracking status for the game/overlay logic.
- Qualifies detection with an acquire/track/coast/lost state machine and smooths with a power-of-two moving average over frames.

Parameters:
- AVG_LOG2, 2, log2 of averaging window depth in frames (window = 4)
- ACQ_FRAMES, 3, consecutive present frames required to enter TRACK
- LOST_FRAMES, 8, consecutive missed frames in COAST before dropping to IDLE
- MAX_JUMP, 64, max per-axis |sample - current output| accepted while tracking, in pixels
- ROW_MAX, 479, sample row clamp
- COL_MAX, 639, sample column clamp

Ports:
- iCLK  input  1  clock
- iRST  input  1  synchronous reset, active-high
- iRow  input  11  detector centroid row
- iCol  input  11  detector centroid column
- iVALID_COORD  input  1  detector frame-boundary level; may stay high several cycles
- iPresent  input  1  detector target-present flag
- oRow  output  11  filtered row
- oCol  output  11  filtered column
- oVALID  output  1  one-cycle pulse: oRow/oCol updated for this frame
- oTracking  output  1  high in TRACK or COAST
- oState  output  2  IDLE=0, ACQUIRE=1, TRACK=2, COAST=3

Behaviour:
- Reset: sync, active-high, overrides every other event on the same edge. oRow=0, oCol=0, oVALID=0, oTracking=0, oState=IDLE. Window buffers, running sums and counters all 0. Edge-detect register = 0.
- Frame tick: iVALID_COORD & ~prev_valid. Exactly one tick per high interval. The first high level after reset counts as a tick.
- On a tick, register the sample: row = min(iRow, ROW_MAX), col = min(iCol, COL_MAX), plus pres = iPresent. This is cycle T.
- Hit: pres and, in TRACK/COAST, |row - oRow| <= MAX_JUMP and |col - oCol| <= MAX_JUMP. In IDLE/ACQUIRE, a hit = pres only. Miss: not a hit.
- State transitions are evaluated at T+1:
  - IDLE, hit: go to ACQUIRE. acq_cnt=1. Preload every window entry with the sample; sum = sample << AVG_LOG2.
  - IDLE, miss: stay in IDLE.
  - ACQUIRE, hit: push sample; acq_cnt+1. When acq_cnt reaches ACQ_FRAMES, go to TRACK. With ACQ_FRAMES=1, go straight from IDLE to TRACK.
  - ACQUIRE, miss: go to IDLE.
  - TRACK, hit: push sample; stay in TRACK.
  - TRACK, miss: go to COAST, miss_cnt=1, no push.
  - COAST, hit: push sample; go to TRACK, miss_cnt=0.
  - COAST, miss: miss_cnt+1. When it reaches LOST_FRAMES, go to IDLE.
- Window: circular buffer of 2^AVG_LOG2 entries per axis. Running sum = sum + new - oldest, width 11+AVG_LOG2, never overflows. Write pointer wraps modulo depth.
- Outputs: at T+2, oRow = row_sum >> AVG_LOG2 and oCol = col_sum >> AVG_LOG2 (truncating). oVALID pulses for one cycle at T+2 when the post-tick state is TRACK or COAST. In COAST, outputs hold their value.
- No oVALID for ticks ending in IDLE or ACQUIRE, including the COAST->IDLE drop. oRow/oCol keep their last values after loss.
- oTracking and oState are registered and change at T+1.
- A new tick arriving before T+2 of the previous one cannot occur, because frames are far longer than 2 cycles; no queuing is required.

Test Plan:
- Reset, then iVALID_COORD held high 5 cycles with iPresent=0 -> one tick only; state stays IDLE; oRow=oCol=0; oVALID never pulses.
- Three ticks with iPresent=1 at (100,200) -> oState 0→1→1→2; oTracking rises at T+1 of the 3rd tick; single oVALID at T+2 with oRow=100, oCol=200.
- In TRACK at (100,200), one tick at (104,208) -> row_sum 404, col_sum 808; oRow=101, oCol=202 with an oVALID pulse.
- In TRACK at (100,200), tick at (300,200) with iPresent=1 -> jump rejected; COAST; oVALID pulses with outputs held at (100,200); next tick at (102,200) -> TRACK; oRow=100 (402>>2).
- From TRACK, 8 absent ticks -> COAST for 7 ticks with oVALID each; 8th tick -> IDLE, oTracking=0, no oVALID, outputs hold.
- ACQUIRE interrupted by an absent tick -> IDLE. Separately, iRST asserted on the same edge as a tick-derived transition -> IDLE, all outputs 0. Separately, iCol=2000 on a tick -> clamped to 639 before averaging.

Source files
------------

// File: rtl/coord_track_filter.sv
// Frame-rate tracker for the red-group centroid: edge-detects the frame strobe,
// qualifies detections through an acquire/track/coast/lost FSM and box-averages accepted samples.
//
// state   | meaning
// IDLE    | no target; waiting for a present frame
// ACQUIRE | consecutive present frames being counted
// TRACK   | locked; accepted samples pushed into the window
// COAST   | locked but recent frames missed; outputs held
module coord_track_filter #(
   parameter int AVG_LOG2    = 2,
   parameter int ACQ_FRAMES  = 3,
   parameter int LOST_FRAMES = 8,
   parameter int MAX_JUMP    = 64,
   parameter int ROW_MAX     = 479,
   parameter int COL_MAX     = 639
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic [10:0] iRow,
   input  logic [10:0] iCol,
   input  logic        iVALID_COORD,
   input  logic        iPresent,
   output logic [10:0] oRow,
   output logic [10:0] oCol,
   output logic        oVALID,
   output logic        oTracking,
   output logic [1:0]  oState
);

   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SW    = 11 + AVG_LOG2;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ACQUIRE = 2'd1;
   localparam logic [1:0] S_TRACK   = 2'd2;
   localparam logic [1:0] S_COAST   = 2'd3;

   localparam logic [10:0] ROW_LIM  = 11'(ROW_MAX);
   localparam logic [10:0] COL_LIM  = 11'(COL_MAX);
   localparam logic [10:0] JUMP_LIM = 11'(MAX_JUMP);
   localparam logic [7:0]  ACQ_LIM  = 8'(ACQ_FRAMES);
   localparam logic [7:0]  LOST_LIM = 8'(LOST_FRAMES);

   logic                prev_valid_q, prev_valid_d;
   logic                smp_vld_q, smp_vld_d;
   logic                smp_pres_q, smp_pres_d;
   logic [10:0]         smp_row_q, smp_row_d;
   logic [10:0]         smp_col_q, smp_col_d;
   logic [1:0]          state_q, state_d;
   logic [7:0]          acq_cnt_q, acq_cnt_d;
   logic [7:0]          miss_cnt_q, miss_cnt_d;
   logic [10:0]         win_row_q [DEPTH];
   logic [10:0]         win_row_d [DEPTH];
   logic [10:0]         win_col_q [DEPTH];
   logic [10:0]         win_col_d [DEPTH];
   logic [AVG_LOG2-1:0] wptr_q, wptr_d;
   logic [SW-1:0]       row_sum_q, row_sum_d;
   logic [SW-1:0]       col_sum_q, col_sum_d;
   logic                upd_q, upd_d;
   logic [10:0]         out_row_q, out_row_d;
   logic [10:0]         out_col_q, out_col_d;
   logic                out_vld_q, out_vld_d;

   logic        tick, hit, near, push, preload;
   logic [10:0] dr, dc;

   always_comb begin
      prev_valid_d = iVALID_COORD;
      tick         = iVALID_COORD & ~prev_valid_q;
      smp_vld_d    = tick;
      smp_pres_d   = smp_pres_q;
      smp_row_d    = smp_row_q;
      smp_col_d    = smp_col_q;
      if (tick) begin
         smp_row_d  = (iRow > ROW_LIM) ? ROW_LIM : iRow;
         smp_col_d  = (iCol > COL_LIM) ? COL_LIM : iCol;
         smp_pres_d = iPresent;
      end

      dr   = (smp_row_q >= out_row_q) ? smp_row_q - out_row_q : out_row_q - smp_row_q;
      dc   = (smp_col_q >= out_col_q) ? smp_col_q - out_col_q : out_col_q - smp_col_q;
      near = (dr <= JUMP_LIM) && (dc <= JUMP_LIM);
      // Jump gating only applies once locked (TRACK/COAST both have bit 1 set)
      hit  = smp_pres_q & (state_q[1] ? near : 1'b1);

      state_d    = state_q;
      acq_cnt_d  = acq_cnt_q;
      miss_cnt_d = miss_cnt_q;
      push       = 1'b0;
      preload    = 1'b0;
      if (smp_vld_q) begin
         case (state_q)
            S_IDLE: if (hit) begin
               preload   = 1'b1;
               acq_cnt_d = 8'd1;
               state_d   = (ACQ_LIM <= 8'd1) ? S_TRACK : S_ACQUIRE;
            end
            S_ACQUIRE: if (hit) begin
               push      = 1'b1;
               acq_cnt_d = acq_cnt_q + 8'd1;
               if (acq_cnt_d >= ACQ_LIM) state_d = S_TRACK;
            end else begin
               acq_cnt_d = 8'd0;
               state_d   = S_IDLE;
            end
            S_TRACK: if (hit) begin
               push = 1'b1;
            end else begin
               miss_cnt_d = 8'd1;
               state_d    = S_COAST;
            end
            default: if (hit) begin
               push       = 1'b1;
               miss_cnt_d = 8'd0;
               state_d    = S_TRACK;
            end else begin
               miss_cnt_d = miss_cnt_q + 8'd1;
               if (miss_cnt_d >= LOST_LIM) begin
                  miss_cnt_d = 8'd0;
                  state_d    = S_IDLE;
               end
            end
         endcase
      end
      upd_d = smp_vld_q & state_d[1];

      win_row_d = win_row_q;
      win_col_d = win_col_q;
      wptr_d    = wptr_q;
      row_sum_d = row_sum_q;
      col_sum_d = col_sum_q;
      if (preload) begin
         for (int i = 0; i < DEPTH; i++) begin
            win_row_d[i] = smp_row_q;
            win_col_d[i] = smp_col_q;
         end
         wptr_d    = '0;
         row_sum_d = SW'(smp_row_q) << AVG_LOG2;
         col_sum_d = SW'(smp_col_q) << AVG_LOG2;
      end else if (push) begin
         row_sum_d         = row_sum_q + SW'(smp_row_q) - SW'(win_row_q[wptr_q]);
         col_sum_d         = col_sum_q + SW'(smp_col_q) - SW'(win_col_q[wptr_q]);
         win_row_d[wptr_q] = smp_row_q;
         win_col_d[wptr_q] = smp_col_q;
         wptr_d            = wptr_q + 1'b1;
      end

      out_vld_d = upd_q;
      out_row_d = out_row_q;
      out_col_d = out_col_q;
      if (upd_q && state_q == S_TRACK) begin
         out_row_d = 11'(row_sum_q >> AVG_LOG2);
         out_col_d = 11'(col_sum_q >> AVG_LOG2);
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         prev_valid_q <= 1'b0;
         smp_vld_q    <= 1'b0;
         smp_pres_q   <= 1'b0;
         smp_row_q    <= '0;
         smp_col_q    <= '0;
         state_q      <= S_IDLE;
         acq_cnt_q    <= '0;
         miss_cnt_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            win_row_q[i] <= '0;
            win_col_q[i] <= '0;
         end
         wptr_q       <= '0;
         row_sum_q    <= '0;
         col_sum_q    <= '0;
         upd_q        <= 1'b0;
         out_row_q    <= '0;
         out_col_q    <= '0;
         out_vld_q    <= 1'b0;
      end else begin
         prev_valid_q <= prev_valid_d;
         smp_vld_q    <= smp_vld_d;
         smp_pres_q   <= smp_pres_d;
         smp_row_q    <= smp_row_d;
         smp_col_q    <= smp_col_d;
         state_q      <= state_d;
         acq_cnt_q    <= acq_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
         win_row_q    <= win_row_d;
         win_col_q    <= win_col_d;
         wptr_q       <= wptr_d;
         row_sum_q    <= row_sum_d;
         col_sum_q    <= col_sum_d;
         upd_q        <= upd_d;
         out_row_q    <= out_row_d;
         out_col_q    <= out_col_d;
         out_vld_q    <= out_vld_d;
      end
   end

   assign oRow      = out_row_q;
   assign oCol      = out_col_q;
   assign oVALID    = out_vld_q;
   assign oState    = state_q;
   assign oTracking = state_q[1];

endmodule

// File: tb/tb_coord_track_filter.sv
// Scenario bench for coord_track_filter: expected outputs are queued per tick
// and matched against every oVALID pulse by a monitor.
module tb_coord_track_filter;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] row_in, col_in;
   logic        vld_in, pres_in;
   logic [10:0] o_row, o_col;
   logic        o_valid, o_tracking;
   logic [1:0]  o_state;

   int checks   = 0;
   int failures = 0;
   logic [21:0] exp_q [$];

   coord_track_filter dut (
      .iCLK         (clk),
      .iRST         (rst),
      .iRow         (row_in),
      .iCol         (col_in),
      .iVALID_COORD (vld_in),
      .iPresent     (pres_in),
      .oRow         (o_row),
      .oCol         (o_col),
      .oVALID       (o_valid),
      .oTracking    (o_tracking),
      .oState       (o_state)
   );

   always #5 clk = ~clk;

   initial begin
      logic [21:0] e;
      forever begin
         @(negedge clk);
         if (o_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_valid got row=%0d col=%0d required no pulse", o_row, o_col);
            end else begin
               e = exp_q.pop_front();
               if ({o_row, o_col} !== e) begin
                  failures++;
                  $display("FAIL scoreboard got row=%0d col=%0d required row=%0d col=%0d",
                           o_row, o_col, e[21:11], e[10:0]);
               end
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; vld_in = 1'b0; pres_in = 1'b0; row_in = '0; col_in = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      checks++;
      if ({o_row, o_col, o_valid, o_tracking, o_state} !== 25'd0) begin
         failures++;
         $display("FAIL reset_state got row=%0d col=%0d v=%b trk=%b st=%0d required all 0",
                  o_row, o_col, o_valid, o_tracking, o_state);
      end
   endtask

   task automatic do_tick(input logic [10:0] r, input logic [10:0] c, input logic p,
                          input int hold, input logic [1:0] est, input logic push,
                          input logic [10:0] er, input logic [10:0] ec);
      int n;
      n = (hold > 3) ? hold : 3;
      if (push) exp_q.push_back({er, ec});
      @(negedge clk);
      row_in = r; col_in = c; pres_in = p; vld_in = 1'b1;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         if (i >= hold) vld_in = 1'b0;
         if (i == 2) begin
            checks++;
            if (o_state !== est || o_tracking !== est[1]) begin
               failures++;
               $display("FAIL tick_state got st=%0d trk=%b required st=%0d trk=%b",
                        o_state, o_tracking, est, est[1]);
            end
            checks++;
            if (o_valid !== 1'b0) begin
               failures++;
               $display("FAIL early_valid got %b required 0 at T+1", o_valid);
            end
         end
         if (i == 3) begin
            checks++;
            if (o_valid !== push) begin
               failures++;
               $display("FAIL valid_timing got %b required %b at T+2", o_valid, push);
            end
         end
      end
      vld_in = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic acquire(input logic [10:0] r, input logic [10:0] c,
                          input logic [10:0] er, input logic [10:0] ec);
      do_tick(r, c, 1'b1, 1, 2'd1, 1'b0, 0, 0);
      do_tick(r, c, 1'b1, 1, 2'd1, 1'b0, 0, 0);
      do_tick(r, c, 1'b1, 1, 2'd2, 1'b1, er, ec);
   endtask

   task automatic check_out(input string nm, input logic [10:0] er, input logic [10:0] ec);
      checks++;
      if (o_row !== er || o_col !== ec) begin
         failures++;
         $display("FAIL %s got row=%0d col=%0d required row=%0d col=%0d", nm, o_row, o_col, er, ec);
      end
   endtask

   task automatic test_idle_hold();
      test_reset();
      do_tick(11'd50, 11'd60, 1'b0, 5, 2'd0, 1'b0, 0, 0);
      check_out("idle_outputs", 11'd0, 11'd0);
   endtask

   task automatic test_acquire();
      test_reset();
      acquire(11'd100, 11'd200, 11'd100, 11'd200);
      check_out("acquire_out", 11'd100, 11'd200);
   endtask

   task automatic test_smooth();
      test_reset();
      acquire(11'd100, 11'd200, 11'd100, 11'd200);
      do_tick(11'd104, 11'd208, 1'b1, 1, 2'd2, 1'b1, 11'd101, 11'd202);
      check_out("smooth_out", 11'd101, 11'd202);
   endtask

   task automatic test_jump();
      test_reset();
      acquire(11'd100, 11'd200, 11'd100, 11'd200);
      do_tick(11'd300, 11'd200, 1'b1, 1, 2'd3, 1'b1, 11'd100, 11'd200);
      do_tick(11'd102, 11'd200, 1'b1, 1, 2'd2, 1'b1, 11'd100, 11'd200);
   endtask

   task automatic test_lost();
      test_reset();
      acquire(11'd100, 11'd200, 11'd100, 11'd200);
      for (int k = 0; k < 7; k++)
         do_tick(11'd0, 11'd0, 1'b0, 1, 2'd3, 1'b1, 11'd100, 11'd200);
      do_tick(11'd0, 11'd0, 1'b0, 1, 2'd0, 1'b0, 0, 0);
      check_out("lost_hold", 11'd100, 11'd200);
   endtask

   task automatic test_acq_abort();
      test_reset();
      do_tick(11'd10, 11'd20, 1'b1, 1, 2'd1, 1'b0, 0, 0);
      do_tick(11'd10, 11'd20, 1'b0, 1, 2'd0, 1'b0, 0, 0);
   endtask

   task automatic test_reset_collision();
      test_reset();
      acquire(11'd100, 11'd200, 11'd100, 11'd200);
      @(negedge clk);
      row_in = 11'd100; col_in = 11'd200; pres_in = 1'b1; vld_in = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({o_row, o_col, o_valid, o_tracking, o_state} !== 25'd0) begin
         failures++;
         $display("FAIL reset_collision got row=%0d col=%0d v=%b trk=%b st=%0d required all 0",
                  o_row, o_col, o_valid, o_tracking, o_state);
      end
      rst = 1'b0; vld_in = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_clamp();
      test_reset();
      acquire(11'd1500, 11'd2000, 11'd479, 11'd639);
      check_out("clamp_out", 11'd479, 11'd639);
   endtask

   initial begin
      rst = 1'b1; vld_in = 1'b0; pres_in = 1'b0; row_in = '0; col_in = '0;
      test_reset();
      test_idle_hold();
      test_acquire();
      test_smooth();
      test_jump();
      test_lost();
      test_acq_abort();
      test_reset_collision();
      test_clamp();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL pending_expected got %0d outstanding required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
